// File: rtl/overlap_add_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : overlap_add_buffer
//  Purpose  : Overlap-add of windowed frames (WIN_LENGTH samples, advanced by
//             HOP_LENGTH) into a circular saturating accumulator. Emits
//             HOP_LENGTH finished samples per frame; flush drains the tail.
//  Revision : 1.0 - initial release
// ============================================================================
module overlap_add_buffer #(
  parameter int WIDTH      = 32,
  parameter int WIN_LENGTH = 480,
  parameter int HOP_LENGTH = 160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic             frame_done,
  output logic             busy,
  output logic             sof_err
);

  localparam int ADDR_WIDTH = $clog2(WIN_LENGTH);
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int CNT_WIDTH  = $clog2(WIN_LENGTH + 1);

  localparam logic [CNT_WIDTH-1:0]  IN_LAST    = CNT_WIDTH'(WIN_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DRAIN_LAST = CNT_WIDTH'(HOP_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0]  FLUSH_LAST = CNT_WIDTH'(WIN_LENGTH - HOP_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] HOP_STEP   = ADDR_WIDTH'(HOP_LENGTH);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                 state;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  base;
  logic [ADDR_WIDTH-1:0]  rp;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_eff;
  logic [CNT_WIDTH-1:0]   dcnt;
  logic [CNT_WIDTH-1:0]   dcnt_last;
  logic                   flush_take;
  logic                   in_take;
  logic                   out_take;
  logic                   sof_bad;
  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       sum_sat;

  // Handshakes, addressing and the saturating read-modify-write datapath.
  always_comb begin
    flush_take = (state == ACCUM) && flush && (cnt == '0);
    in_ready   = (state == ACCUM) && !(flush && (cnt == '0));
    in_take    = in_valid && in_ready;
    out_valid  = (state != ACCUM);
    busy       = (state != ACCUM);
    out_take   = out_valid && out_ready;
    dcnt_last  = (state == FLUSH) ? FLUSH_LAST : DRAIN_LAST;
    frame_done = (state == DRAIN) && out_ready && (dcnt == DRAIN_LAST);
    out_data   = out_valid ? mem[rp] : '0;
    // A start-of-frame (expected or not) always lands on frame index 0.
    cnt_eff    = (in_sof || (cnt == '0)) ? '0 : cnt;
    sof_bad    = in_sof != (cnt == '0);
    wr_addr    = base + ADDR_WIDTH'(cnt_eff);
    sum        = {mem[wr_addr][WIDTH-1], mem[wr_addr]} + {in_data[WIDTH-1], in_data};
    // Overflow when the extra sign bit disagrees with the result MSB.
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      sum_sat = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_sat = sum[WIDTH-1:0];
    end
  end

  // Accumulator memory: add on input accept, clear each word as it is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (in_take && !flush_take) begin
      mem[wr_addr] <= sum_sat;
    end else if (out_take) begin
      mem[rp] <= '0;
    end
  end

  // Control FSM: accumulate a frame, then drain a hop (or flush the tail).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACCUM;
      base    <= '0;
      cnt     <= '0;
      dcnt    <= '0;
      rp      <= '0;
      sof_err <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (flush_take) begin
            rp    <= base;
            dcnt  <= '0;
            state <= FLUSH;
          end else if (in_take) begin
            if (sof_bad) begin
              sof_err <= 1'b1;
            end
            if (cnt_eff == IN_LAST) begin
              cnt   <= '0;
              rp    <= base;
              dcnt  <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt_eff + CNT_WIDTH'(1);
            end
          end
        end
        DRAIN, FLUSH: begin
          if (out_take) begin
            rp   <= rp + ADDR_WIDTH'(1);
            dcnt <= dcnt + CNT_WIDTH'(1);
            if (dcnt == dcnt_last) begin
              state <= ACCUM;
              base  <= (state == DRAIN) ? base + HOP_STEP : '0;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_overlap_add_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_overlap_add_buffer
//  Purpose  : Randomised self-checking bench; a 16-bit and an 8-bit instance
//             share stimulus and are compared against an array-based
//             overlap-add model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_overlap_add_buffer;

  localparam int WIN = 8;
  localparam int HOP = 4;
  localparam int TD  = 8;

  logic        clk, rst, in_valid, in_sof, flush, out_ready;
  logic [15:0] in_data;
  logic [7:0]  in_data8;
  logic        in_ready, out_valid, frame_done, busy, sof_err;
  logic [15:0] out_data;
  logic        in_ready8, out_valid8, frame_done8, busy8, sof_err8;
  logic [7:0]  out_data8;

  assign in_data8 = in_data[7:0];

  overlap_add_buffer #(.WIDTH(16), .WIN_LENGTH(WIN), .HOP_LENGTH(HOP)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .frame_done(frame_done), .busy(busy), .sof_err(sof_err));

  overlap_add_buffer #(.WIDTH(8), .WIN_LENGTH(WIN), .HOP_LENGTH(HOP)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_sof(in_sof),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .flush(flush), .frame_done(frame_done8), .busy(busy8), .sof_err(sof_err8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one accumulator array per sample width.
  longint acc16 [TD];
  longint acc8  [TD];
  longint q16 [$];
  longint q8  [$];
  int     mbase, mcnt;
  bit     merr;

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TD; i++) begin
      acc16[i] = 0;
      acc8[i]  = 0;
    end
    q16.delete();
    q8.delete();
    mbase = 0;
    mcnt  = 0;
    merr  = 0;
  endtask

  task automatic model_emit(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a = (mbase + k) % TD;
      q16.push_back(acc16[a]);
      q8.push_back(acc8[a]);
      acc16[a] = 0;
      acc8[a]  = 0;
    end
  endtask

  task automatic model_accept(input logic [15:0] v, input bit sof);
    int idx, a;
    if (sof || mcnt == 0) begin
      if (sof != (mcnt == 0)) merr = 1;
      idx = 0;
    end else begin
      idx = mcnt;
    end
    a = (mbase + idx) % TD;
    acc16[a] = sat(acc16[a] + longint'($signed(v)), 16);
    acc8[a]  = sat(acc8[a] + longint'($signed(v[7:0])), 8);
    if (idx == WIN - 1) begin
      mcnt = 0;
      model_emit(HOP);
      mbase = (mbase + HOP) % TD;
    end else begin
      mcnt = idx + 1;
    end
  endtask

  // All drive tasks start and end at posedge+1; outputs are sampled at negedge.
  task automatic push(input logic [15:0] v, input bit sof, input bit fl);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = v;
    flush    = fl;
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    chk("in_ready8", in_ready8, 1);
    chk("busy_accum", busy, 0);
    chk("valid_accum", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    flush    = 1'b0;
    model_accept(v, sof);
  endtask

  task automatic send_frame(input int kind, input int val);
    logic [15:0] v;
    for (int i = 0; i < WIN; i++) begin
      case (kind)
        0:       v = 16'(val);
        1:       v = 16'(i + 1);
        default: v = 16'($urandom);
      endcase
      push(v, i == 0, 1'b0);
    end
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    @(negedge clk);
    chk("in_ready_flush", in_ready, 0);
    chk("in_ready8_flush", in_ready8, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    model_emit(WIN - HOP);
    mbase = 0;
  endtask

  // mode: 0 always ready, 1 random ready, 2 pattern 1,0,0,1 then ready.
  task automatic collect(input int n_stop, input int n_full, input bit is_flush,
                         input int mode, input bit finish);
    int          got, cyc;
    bit          hold;
    logic [15:0] held;
    bit          pat [4];
    longint      e16, e8;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    got  = 0;
    cyc  = 0;
    hold = 0;
    held = '0;
    while (got < n_stop && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc < 4) ? pat[cyc] : 1'b1;
      endcase
      @(negedge clk);
      chk("out_valid", out_valid, 1);
      chk("out_valid8", out_valid8, 1);
      chk("busy", busy, 1);
      chk("in_ready_drain", in_ready, 0);
      if (hold) chk("data_stable", out_data, held);
      if (out_ready) begin
        e16 = (q16.size() > 0) ? q16.pop_front() : 64'hDEAD;
        e8  = (q8.size() > 0) ? q8.pop_front() : 64'hDEAD;
        chk("data16", longint'($signed(out_data)), e16);
        chk("data8", longint'($signed(out_data8)), e8);
        chk("frame_done", frame_done, !is_flush && got == n_full - 1);
        chk("frame_done8", frame_done8, !is_flush && got == n_full - 1);
        got++;
        hold = 0;
      end else begin
        chk("frame_done_stall", frame_done, 0);
        held = out_data;
        hold = 1;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    if (got < n_stop) chk("drain_timeout", got, n_stop);
    if (mode == 0) chk("busy_cycles", cyc, n_stop);
    if (finish) begin
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("busy8_after", busy8, 0);
      chk("valid_after", out_valid, 0);
      chk("sof_err", sof_err, merr);
      chk("sof_err8", sof_err8, merr);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Two frames of ones, flush the tail, then a fresh frame from base 0.
    send_frame(0, 1);  collect(HOP, HOP, 0, 0, 1);
    send_frame(0, 1);  collect(HOP, HOP, 0, 0, 1);
    do_flush();        collect(WIN - HOP, WIN - HOP, 1, 0, 1);
    send_frame(0, 1);  collect(HOP, HOP, 0, 0, 1);
    do_flush();        collect(WIN - HOP, WIN - HOP, 1, 0, 1);

    // Back-pressure with a ramp.
    send_frame(1, 0);  collect(HOP, HOP, 0, 2, 1);
    do_flush();        collect(WIN - HOP, WIN - HOP, 1, 1, 1);

    // Saturation in both directions.
    send_frame(0, 100);  collect(HOP, HOP, 0, 0, 1);
    send_frame(0, 100);  collect(HOP, HOP, 0, 0, 1);
    do_flush();          collect(WIN - HOP, WIN - HOP, 1, 0, 1);
    send_frame(0, -100); collect(HOP, HOP, 0, 0, 1);
    send_frame(0, -100); collect(HOP, HOP, 0, 0, 1);
    do_flush();          collect(WIN - HOP, WIN - HOP, 1, 0, 1);

    // Misplaced start-of-frame, then an ignored flush mid-frame.
    push(16'd3, 1'b1, 1'b0);
    push(16'd3, 1'b0, 1'b0);
    for (int i = 0; i < WIN; i++) begin
      push(16'(10 + i), i == 0, i == 5);
    end
    collect(HOP, HOP, 0, 0, 1);
    send_frame(0, 1);
    collect(HOP, HOP, 0, 1, 1);
    chk("sof_err_sticky", sof_err, 1);

    // Asynchronous reset in the middle of a drain.
    send_frame(0, 1);
    collect(2, HOP, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_busy8", busy8, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    send_frame(0, 1);
    collect(HOP, HOP, 0, 0, 1);

    // Long run of constant frames to wrap the base pointer repeatedly.
    for (int f = 0; f < 200; f++) begin
      send_frame(0, 1);
      collect(HOP, HOP, 0, 0, 1);
    end
    do_flush();
    collect(WIN - HOP, WIN - HOP, 1, 0, 1);

    // Random data, random back-pressure, occasional flush.
    for (int f = 0; f < 40; f++) begin
      send_frame(2, 0);
      collect(HOP, HOP, 0, 1, 1);
      if ($urandom_range(0, 3) == 0) begin
        do_flush();
        collect(WIN - HOP, WIN - HOP, 1, 1, 1);
      end
    end
    do_flush();
    collect(WIN - HOP, WIN - HOP, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/overlap_add_buffer.md
Name: overlap_add_buffer

Overview:
- Synthesis-side counterpart of the analysis framing buffer in the MEL/STFT pipeline: accepts windowed frames of WIN_LENGTH samples (e.g. from the inverse-FFT/window stage) and overlap-adds consecutive frames offset by HOP_LENGTH.
- Emits a continuous stream of HOP_LENGTH finished samples per input frame.
- Circular accumulator memory of DEPTH = 2**$clog2(WIN_LENGTH) words.
- A flush command drains the final tail at end of stream.

Parameters:
WIDTH, 32, signed two's-complement sample width (in and out)
WIN_LENGTH, 480, samples per input frame; must be > HOP_LENGTH
HOP_LENGTH, 160, frame advance = samples emitted per frame

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input sample valid
in_ready  output  1  block can accept an input sample
in_sof  input  1  marks first sample of a frame; qualified by in_valid&in_ready
in_data  input  WIDTH  signed windowed sample
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts output sample
out_data  output  WIDTH  finished overlap-added sample
flush  input  1  single-cycle request to drain the WIN_LENGTH-HOP_LENGTH tail
frame_done  output  1  one-cycle pulse when a frame's HOP_LENGTH outputs have all been accepted
busy  output  1  high in DRAIN or FLUSH
sof_err  output  1  sticky: in_sof seen mid-frame, or missing at sample 0

Behaviour:
- Reset (async, rst=1): state ACCUM, base pointer=0, sample counter=0, read pointer=0, all memory words=0. Outputs: in_ready=1 once rst deasserts, out_valid=0, out_data=0, frame_done=0, busy=0, sof_err=0.
- Internal: base (ADDR_WIDTH=$clog2(DEPTH)), sample counter cnt (0..WIN_LENGTH-1), drain counter dcnt, read pointer rp. All address arithmetic wraps modulo DEPTH.
- ACCUM state:
  - in_ready = 1 & ~(flush & cnt==0).
  - On an accepted sample: mem[(base+cnt) mod DEPTH] <= sat(mem[...] + in_data). This is a read-modify-write in one cycle using an asynchronous memory read.
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - cnt increments on each accepted sample.
  - If in_sof=1 while cnt!=0: set sof_err, treat the sample as sample 0 (cnt restarts), and keep the partial sums already written.
  - If in_sof=0 at cnt==0: set sof_err and accept the sample as sample 0.
  - On the accepted sample with cnt==WIN_LENGTH-1: cnt<=0, rp<=base, dcnt<=0, go to DRAIN next cycle.
- DRAIN state:
  - in_ready=0, out_valid=1, out_data = mem[rp] (combinational from memory; stable while out_ready=0).
  - On out_valid&out_ready: mem[rp]<=0, rp<=rp+1, dcnt++.
  - On the handshake with dcnt==HOP_LENGTH-1: base<=base+HOP_LENGTH, frame_done pulses that cycle, return to ACCUM. First new input can be accepted the following cycle.
- flush:
  - Honoured only in ACCUM with cnt==0; ignored otherwise (no error).
  - Has priority over a simultaneous in_valid: the sample is not accepted that cycle.
  - Action: rp<=base, dcnt<=0, go to FLUSH.
- FLUSH state:
  - Same handshake as DRAIN, but emits WIN_LENGTH-HOP_LENGTH samples, zeroing each word as it is emitted.
  - After the last handshake: base<=0, return to ACCUM. No frame_done pulse.
  - Memory is then entirely zero.
- Throughput:
  - One input sample per cycle in ACCUM; one output per cycle in DRAIN/FLUSH when out_ready=1.
  - Latency from the last input sample to the first out_valid: 1 cycle.
- busy = (state != ACCUM).
- sof_err clears only on rst.
- rst asserted mid-DRAIN/FLUSH/ACCUM: immediate return to reset values; partial frames and sums are discarded.

Test Plan:
- WIN=8, HOP=4, WIDTH=16. One frame of eight samples, value 1, in_sof on the first, out_ready=1 -> out_data 1,1,1,1; frame_done pulses on the 4th handshake; busy=1 for exactly 4 cycles.
- Same config, second frame of eight 1s -> outputs 2,2,2,2. Then flush -> tail outputs 1,1,1,1, no frame_done, busy drops. A third frame of 1s -> outputs 1,1,1,1 (memory was cleared, base=0).
- Back-pressure: out_ready toggled 1,0,0,1 during DRAIN with ramp input 1..8 -> outputs 1,2,3,4 in order; out_data held stable while out_ready=0; in_ready=0 throughout.
- Saturation, WIDTH=8: two frames of all 100 -> second-frame outputs 127 (not -56). Two frames of all -100 -> -128.
- Protocol: in_sof asserted on the 3rd sample of a frame -> sof_err=1 and stays 1. The frame completes 8 samples after the restart, then drains normally. flush asserted at cnt=5 -> ignored, no state change.
- Async reset asserted mid-DRAIN after 2 outputs -> out_valid=0 and busy=0 immediately. A subsequent frame of 1s outputs 1,1,1,1 (no residue).
- Wrap-around: 200 consecutive frames of constant 1 with WIN=8, HOP=4 -> every output after the first frame equals 2; base wraps modulo 8 without glitches.
